// File: rtl/nios_system_onchip_memory_arbiter.sv
// Two-master round-robin arbiter in front of the single-port on-chip memory.
// m0 is the Nios II data master and m1 is the DMA/streaming master. A request
// is granted combinationally in the cycle it is presented. The current owner
// keeps the memory for at most HOLD_MAX consecutive accesses while the other
// master is waiting. Read data returns one cycle after acceptance, tagged to
// the master that issued the read.
module nios_system_onchip_memory_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] HOLD = 8'(HOLD_MAX);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_q, last_d;   // owner before the last return to IDLE
  logic       pend0_q, pend1_q; // read accepted last cycle, per master
  logic       req0, req1, gnt0, gnt1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant and next-state: round-robin from IDLE, bounded bursts while owned.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) begin
          gnt0 = 1'b1; state_d = OWN0; cnt_d = 8'd1;
        end else if (req1) begin
          gnt1 = 1'b1; state_d = OWN1; cnt_d = 8'd1;
        end
      end
      OWN0: begin
        if (req0 && (!req1 || cnt_q < HOLD)) begin
          gnt0  = 1'b1;
          cnt_d = (cnt_q < HOLD) ? cnt_q + 8'd1 : HOLD;
        end else if (req1) begin
          gnt1 = 1'b1; state_d = OWN1; cnt_d = 8'd1;
        end else begin
          state_d = IDLE; cnt_d = 8'd0; last_d = 1'b0;
        end
      end
      OWN1: begin
        if (req1 && (!req0 || cnt_q < HOLD)) begin
          gnt1  = 1'b1;
          cnt_d = (cnt_q < HOLD) ? cnt_q + 8'd1 : HOLD;
        end else if (req0) begin
          gnt0 = 1'b1; state_d = OWN0; cnt_d = 8'd1;
        end else begin
          state_d = IDLE; cnt_d = 8'd0; last_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // No access may reach the memory while reset is high.
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Arbitration state and one-cycle read-return tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      last_q  <= 1'b1;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      pend0_q <= gnt0 & m0_read & ~m0_write;
      pend1_q <= gnt1 & m1_read & ~m1_write;
    end
  end

  // Memory mux defaults to m0 when nothing is granted (values are don't-care).
  assign mem_address    = gnt1 ? m1_address    : m0_address;
  assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
  assign mem_clken      = ~reset;

  assign m0_waitrequest = reset | (req0 & ~gnt0);
  assign m1_waitrequest = reset | (req1 & ~gnt1);

  // A read tagged in the cycle before reset must not surface during reset.
  assign m0_readdatavalid = pend0_q & ~reset;
  assign m1_readdatavalid = pend1_q & ~reset;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_nios_system_onchip_memory_arbiter.sv
// Bench for the two-master on-chip memory arbiter: a behavioural memory on
// the s1 side, and a transaction-level model of who should own the memory
// and what each read should return.
module tb_nios_system_onchip_memory_arbiter;
  localparam int HOLD = 4;
  localparam int AW   = 16;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [31:0]   wd;
  } mreq_t;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [3:0]    m0_byteenable, m1_byteenable, mem_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [31:0]   m0_writedata, m1_writedata, mem_writedata;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0]   m0_readdata, m1_readdata, mem_readdata;
  logic          mem_chipselect, mem_write, mem_clken;

  always #5 clk = ~clk;

  nios_system_onchip_memory_arbiter #(.HOLD_MAX(HOLD), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Behavioural single-port memory with one-cycle read latency.
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Reference model: expected memory contents, owner/streak tracking,
  // and the read each master should see on the next cycle.
  logic [31:0] exp_mem [0:(1<<AW)-1];
  int          own, streak, last;
  logic        pv0, pv1;
  logic [31:0] pd0, pd1;

  int checks = 0, failures = 0;

  // Per-cycle observed and expected values for the test tasks to compare.
  logic [6:0]    obs_ctl, exp_ctl;
  logic [AW-1:0] obs_addr, exp_addr;
  logic [31:0]   obs_wd, exp_wd, obs_rd0, obs_rd1, exp_rd0, exp_rd1;
  logic [3:0]    obs_be, exp_be;
  logic          exp_rdv0, exp_rdv1;
  int            exp_g;

  function automatic mreq_t idle_req();
    mreq_t q;
    q.rd = 0; q.wr = 0; q.a = '0; q.be = 4'hF; q.wd = '0;
    return q;
  endfunction

  function automatic mreq_t mk(input logic rd, input logic wr, input logic [AW-1:0] a,
                               input logic [3:0] be, input logic [31:0] wd);
    mreq_t q;
    q.rd = rd; q.wr = wr; q.a = a; q.be = be; q.wd = wd;
    return q;
  endfunction

  function automatic mreq_t rnd_req(input int pct);
    mreq_t q;
    q.rd = ($urandom_range(99) < pct);
    q.wr = ($urandom_range(99) < pct / 2);
    q.a  = AW'($urandom_range(31));
    q.be = 4'($urandom_range(15));
    q.wd = $urandom;
    return q;
  endfunction

  // Drive one cycle, predict, capture outputs, then advance the model.
  task automatic run_cycle(input logic rst, input mreq_t q0, input mreq_t q1);
    logic  r0, r1, ro, rx;
    mreq_t s;
    reset = rst;
    m0_address = q0.a; m0_byteenable = q0.be; m0_read = q0.rd; m0_write = q0.wr; m0_writedata = q0.wd;
    m1_address = q1.a; m1_byteenable = q1.be; m1_read = q1.rd; m1_write = q1.wr; m1_writedata = q1.wd;
    r0 = q0.rd | q0.wr;
    r1 = q1.rd | q1.wr;
    if (rst) exp_g = -1;
    else if (own < 0) exp_g = (r0 && r1) ? ((last == 1) ? 0 : 1) : (r0 ? 0 : (r1 ? 1 : -1));
    else begin
      ro = (own == 1) ? r1 : r0;
      rx = (own == 1) ? r0 : r1;
      if (ro && (!rx || streak < HOLD)) exp_g = own;
      else if (rx) exp_g = 1 - own;
      else exp_g = -1;
    end
    s = (exp_g == 1) ? q1 : q0;
    exp_rdv0 = !rst && pv0;
    exp_rdv1 = !rst && pv1;
    exp_rd0  = pd0;
    exp_rd1  = pd1;
    exp_ctl  = {rst || (r0 && exp_g != 0), rst || (r1 && exp_g != 1), exp_g >= 0,
                exp_g >= 0 && s.wr, exp_rdv0, exp_rdv1, !rst};
    exp_addr = s.a; exp_be = s.be; exp_wd = s.wd;
    #1;
    obs_ctl  = {m0_waitrequest, m1_waitrequest, mem_chipselect, mem_write,
                m0_readdatavalid, m1_readdatavalid, mem_clken};
    obs_addr = mem_address; obs_be = mem_byteenable; obs_wd = mem_writedata;
    obs_rd0  = m0_readdata; obs_rd1 = m1_readdata;
    @(posedge clk);
    pv0 = 0; pv1 = 0;
    if (rst) begin
      own = -1; streak = 0; last = 1;
    end else begin
      if (exp_g < 0) begin
        if (own >= 0) last = own;
        own = -1; streak = 0;
      end else if (exp_g == own) begin
        streak = (streak < HOLD) ? streak + 1 : HOLD;
      end else begin
        own = exp_g; streak = 1;
      end
      if (exp_g >= 0) begin
        if (s.wr) begin
          for (int b = 0; b < 4; b++)
            if (s.be[b]) exp_mem[s.a][8*b +: 8] = s.wd[8*b +: 8];
        end else if (exp_g == 0) begin
          pv0 = 1; pd0 = exp_mem[s.a];
        end else begin
          pv1 = 1; pd1 = exp_mem[s.a];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    mreq_t rq0, rq1;
    rq0 = mk(1, 0, 16'h0001, 4'hF, 0);
    rq1 = mk(1, 0, 16'h0002, 4'hF, 0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1, rq0, rq1);
      checks++;
      if (obs_ctl !== 7'b1100000) begin
        failures++; $display("FAIL reset_ctl cyc%0d got=%b want=1100000", i, obs_ctl);
      end
    end
    run_cycle(0, rq0, rq1);
    checks++;
    if (obs_ctl[6:5] !== 2'b01 || obs_ctl[4] !== 1'b1) begin
      failures++; $display("FAIL reset_first_grant got wr0/wr1/cs=%b want=011", obs_ctl[6:4]);
    end
    run_cycle(0, idle_req(), idle_req());
    run_cycle(0, idle_req(), idle_req());
  endtask

  task automatic test_m0_write_read();
    run_cycle(0, mk(0, 1, 16'h0010, 4'hF, 32'hDEADBEEF), idle_req());
    checks++;
    if (obs_ctl[6] !== 1'b0 || obs_ctl[4:3] !== 2'b11 || obs_addr !== 16'h0010 || obs_wd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL m0_write got ctl=%b addr=%h wd=%h want wr0=0 cs=1 we=1 addr=0010 wd=deadbeef", obs_ctl, obs_addr, obs_wd);
    end
    run_cycle(0, mk(1, 0, 16'h0010, 4'hF, 0), idle_req());
    checks++;
    if (obs_ctl[6] !== 1'b0 || obs_ctl[4:3] !== 2'b10) begin
      failures++; $display("FAIL m0_read_accept got ctl=%b want wr0=0 cs=1 we=0", obs_ctl);
    end
    run_cycle(0, idle_req(), idle_req());
    checks++;
    if (obs_ctl[2:1] !== 2'b10 || obs_rd0 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL m0_read_return got rdv=%b data=%h want rdv=10 data=deadbeef", obs_ctl[2:1], obs_rd0);
    end
  endtask

  task automatic test_contention();
    int errs = 0;
    run_cycle(1, idle_req(), idle_req());
    for (int i = 0; i < 24; i++) begin
      run_cycle(0, mk(1, 0, AW'(16'h0100 + i), 4'hF, 0), mk(1, 0, AW'(16'h0200 + i), 4'hF, 0));
      checks++;
      if (obs_ctl[6:4] !== {(i % 8) >= 4, (i % 8) < 4, 1'b1}) begin
        failures++; $display("FAIL contention_grant cyc%0d got wr0/wr1/cs=%b want=%b%b1", i, obs_ctl[6:4], (i % 8) >= 4, (i % 8) < 4);
      end
      if (obs_ctl !== exp_ctl) errs++;
      if ((exp_rdv0 && obs_rd0 !== exp_rd0) || (exp_rdv1 && obs_rd1 !== exp_rd1)) errs++;
      if (obs_addr !== exp_addr) errs++;
    end
    run_cycle(0, idle_req(), idle_req());
    checks++;
    if (obs_ctl !== exp_ctl || obs_rd1 !== exp_rd1 || errs != 0) begin
      failures++; $display("FAIL contention_model errs=%0d last ctl=%b want=%b", errs, obs_ctl, exp_ctl);
    end
  endtask

  task automatic test_byte_lane();
    run_cycle(0, idle_req(), mk(0, 1, 16'h0005, 4'hF, 32'h11223344));
    run_cycle(0, idle_req(), mk(0, 1, 16'h0005, 4'h2, 32'h0000AB00));
    checks++;
    if (obs_ctl[5] !== 1'b0 || obs_be !== 4'h2 || obs_wd !== 32'h0000AB00) begin
      failures++; $display("FAIL byte_lane_write got wr1=%b be=%h wd=%h want 0/2/0000ab00", obs_ctl[5], obs_be, obs_wd);
    end
    run_cycle(0, idle_req(), mk(1, 0, 16'h0005, 4'hF, 0));
    run_cycle(0, idle_req(), idle_req());
    checks++;
    if (obs_ctl[2:1] !== 2'b01 || obs_rd1 !== 32'h1122AB44) begin
      failures++; $display("FAIL byte_lane_read got rdv=%b data=%h want rdv=01 data=1122ab44", obs_ctl[2:1], obs_rd1);
    end
    run_cycle(0, idle_req(), idle_req());
  endtask

  task automatic test_owner_release();
    run_cycle(0, mk(1, 0, 16'h0003, 4'hF, 0), idle_req());
    run_cycle(0, mk(1, 0, 16'h0004, 4'hF, 0), idle_req());
    run_cycle(0, idle_req(), mk(1, 0, 16'h0007, 4'hF, 0));
    checks++;
    if (obs_ctl[5:4] !== 2'b01 || obs_addr !== 16'h0007) begin
      failures++; $display("FAIL release_switch got wr1/cs=%b addr=%h want 01/0007", obs_ctl[5:4], obs_addr);
    end
    run_cycle(0, idle_req(), idle_req());
    run_cycle(0, mk(1, 0, 16'h0008, 4'hF, 0), mk(1, 0, 16'h0009, 4'hF, 0));
    checks++;
    if (obs_ctl[6:5] !== 2'b01 || obs_addr !== 16'h0008) begin
      failures++; $display("FAIL release_idle_tie got wr0/wr1=%b addr=%h want 01/0008", obs_ctl[6:5], obs_addr);
    end
    run_cycle(0, idle_req(), idle_req());
    run_cycle(0, idle_req(), idle_req());
  endtask

  task automatic test_reset_mid_read();
    logic seen = 0;
    run_cycle(0, idle_req(), mk(1, 0, 16'h0005, 4'hF, 0));
    run_cycle(1, idle_req(), idle_req());
    seen = seen | obs_ctl[1] | obs_ctl[4];
    run_cycle(0, idle_req(), idle_req());
    seen = seen | obs_ctl[1];
    run_cycle(0, idle_req(), idle_req());
    seen = seen | obs_ctl[1];
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL reset_mid_read got rdv1_or_cs=%b want=0", seen);
    end
    run_cycle(0, mk(1, 0, 16'h0001, 4'hF, 0), mk(1, 0, 16'h0002, 4'hF, 0));
    checks++;
    if (obs_ctl[6:5] !== 2'b01) begin
      failures++; $display("FAIL reset_mid_read_tie got wr0/wr1=%b want=01", obs_ctl[6:5]);
    end
    run_cycle(0, idle_req(), idle_req());
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      run_cycle(($urandom_range(59) == 0), rnd_req(70), rnd_req(70));
      checks++;
      if (obs_ctl !== exp_ctl ||
          (exp_rdv0 && obs_rd0 !== exp_rd0) || (exp_rdv1 && obs_rd1 !== exp_rd1) ||
          (exp_g >= 0 && (obs_addr !== exp_addr || obs_be !== exp_be || obs_wd !== exp_wd))) begin
        failures++; errs++;
        if (errs < 10)
          $display("FAIL random cyc%0d ctl=%b want=%b addr=%h want=%h rd0=%h want=%h rd1=%h want=%h",
                   i, obs_ctl, exp_ctl, obs_addr, exp_addr, obs_rd0, exp_rd0, obs_rd1, exp_rd1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = '0;
      exp_mem[i] = '0;
    end
    mem_readdata = '0;
    own = -1; streak = 0; last = 1;
    pv0 = 0; pv1 = 0; pd0 = '0; pd1 = '0;
    reset = 1;
    m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
    m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
    @(negedge clk);
    test_reset();
    test_m0_write_read();
    test_contention();
    test_byte_lane();
    test_owner_release();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_system_onchip_memory_arbiter.md
# nios_system_onchip_memory_arbiter

Two-master arbiter that shares the single-port on-chip memory (32-bit data, 16-bit word address, 4 byte lanes, one-cycle read latency) between the Nios II data master (m0) and a secondary DMA/streaming master (m1). It sits between the two Avalon-MM masters and the memory's s1 port. Arbitration is round-robin with bounded ownership bursts. Read responses are returned to the originating master with readdatavalid.

## Interface
Parameters:
- HOLD_MAX, 4: maximum consecutive accesses by the current owner while the other master waits; legal range 1..255.
- ADDR_W, 16: word address width.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- m0_address / m1_address  in  ADDR_W  word address.
- m0_byteenable / m1_byteenable  in  4  byte lane enables.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  32  write data.
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle.
- m0_readdata / m1_readdata  out  32  read data; valid only with readdatavalid.
- m0_readdatavalid / m1_readdatavalid  out  1  read response strobe.
- mem_address  out  ADDR_W  to memory address.
- mem_byteenable  out  4  to memory byteenable.
- mem_chipselect  out  1  access this cycle.
- mem_write  out  1  write strobe.
- mem_writedata  out  32  to memory writedata.
- mem_clken  out  1  memory clock enable; equals ~reset.
- mem_readdata  in  32  memory output; valid one cycle after the address is presented.

## Operation
- reqN = mN_read | mN_write. If both read and write are asserted, the access is treated as a write.
- FSM states:
  - IDLE: no owner.
  - OWN0: m0 is the owner.
  - OWN1: m1 is the owner.
- State registers: 8-bit burst counter cnt, and last_owner. Reset values: IDLE, cnt=0, last_owner=1, so m0 wins the first tie.
- Grant is combinational from the state and the requests. Exactly one master, or none, is granted per cycle:
  - IDLE, single request: grant the requester; go OWNx; cnt=1.
  - IDLE, both requesting: grant the master other than last_owner; go OWNx; cnt=1.
  - OWNx, reqx=1 and (other idle or cnt<HOLD_MAX): grant x; cnt=min(cnt+1, HOLD_MAX).
  - OWNx, reqx=1, other requesting and cnt==HOLD_MAX: grant other; go OWNother; cnt=1.
  - OWNx, reqx=0, other requesting: grant other; go OWNother; cnt=1.
  - OWNx, no requests: go IDLE; cnt=0; last_owner=x.
- Granted master: waitrequest=0. Non-granted requester: waitrequest=1. Non-requesting master: waitrequest=0 (don't-care).
- Memory port outputs:
  - Granted cycle: mem_chipselect=1, mem_write=write of granted master, and address/byteenable/writedata muxed from the granted master.
  - No grant: mem_chipselect=0, mem_write=0; other mem_* outputs hold the m0 values (don't-care).
- Read return: on an accepted read, register pend0 or pend1 for one cycle. Next cycle: mN_readdatavalid=pendN and mN_readdata=mem_readdata (both masters' readdata wires are driven from mem_readdata).

## Timing
- Grant latency: 0 cycles when the memory is free. A request is accepted in the same cycle it is presented.
- Read latency: readdatavalid exactly 1 cycle after acceptance. Back-to-back reads sustain 1 access per cycle with no bubbles, including across an owner switch.
- Worst-case wait for a requesting master: HOLD_MAX cycles. HOLD_MAX=1 gives strict alternation under contention.
- Write completes on the accepting edge. A read of the same address on the next cycle returns the new data.
- During reset (all outputs synchronous to clk):
  - both waitrequest=1;
  - mem_chipselect=0, mem_write=0, mem_clken=0;
  - readdatavalid=0 on both masters; pend0 and pend1 cleared.
- Reset mid-operation: a read accepted in the cycle before reset produces no readdatavalid. No access is issued in any cycle with reset=1.
- The first cycle after reset deasserts arbitrates from IDLE with m0 priority.

## Test plan
- Reset with both masters requesting reads for 3 cycles -> both waitrequest=1, mem_chipselect=0, no readdatavalid. In the first cycle after release, m0 is granted (m0_waitrequest=0, m1_waitrequest=1).
- m0 alone: write addr 0x0010 data 0xDEADBEEF be 0xF, then read 0x0010 on the next cycle -> both accepted with no wait. m0_readdatavalid=1 with 0xDEADBEEF on the cycle after the read. m1_readdatavalid stays 0.
- HOLD_MAX=4, both masters issuing continuous reads to distinct addresses -> grant pattern m0×4, m1×4, m0×4… Every read returns the correct data to the correct master, one cycle after acceptance, and memory throughput is 1 per cycle.
- Byte-lane write: preload 0x11223344 at addr 5, then m1 writes 0x0000AB00 with be 0x2 -> m1 reads back 0x1122AB44.
- Owner release: m0 owns with cnt=2, m0 drops its request while m1 requests in the same cycle -> m1 is granted in that cycle. With no requests, the FSM returns to IDLE, and the next simultaneous request is granted to m0 (last_owner=1).
- Reset mid-read: m1 read accepted, reset asserted on the next edge -> m1_readdatavalid never asserts. After reset, all state matches the reset values.
